// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: widths, FIFO entry, grant source.
package wb_port_arbiter_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned NREG  = 32;

  typedef struct packed {
    logic             live;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_FIFO,
    GNT_BYPASS
  } wb_gnt_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Long-latency result FIFO with per-entry live bits, kill-by-destination and a
// pending-destination mask for the hazard unit.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [REG_W-1:0] i_push_rd,
  input  logic [XLEN-1:0]  i_push_data,
  input  logic             i_pop,
  input  logic             i_kill_en,
  input  logic [REG_W-1:0] i_kill_rd,
  output wb_entry_t        o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [NREG-1:0]  o_pending_mask
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_rd_idx;
  logic [NREG-1:0]  w_mask;

  assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
  assign w_rd_idx = r_rd_ptr[PTR_W-1:0];
  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) && (w_wr_idx == w_rd_idx);
  assign o_head   = r_mem[w_rd_idx];

  // Kill first, then pop, then push: a same-cycle enqueue to the killed rd stays live.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[PTR_W'(i)] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (i_kill_en && r_mem[PTR_W'(i)].live && (r_mem[PTR_W'(i)].rd == i_kill_rd)) begin
          r_mem[PTR_W'(i)].live <= 1'b0;
        end
      end
      if (i_pop && !o_empty) begin
        r_mem[w_rd_idx].live <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + (PTR_W+1)'(1);
      end
      if (i_push && !o_full) begin
        r_mem[w_wr_idx] <= '{live: 1'b1, rd: i_push_rd, data: i_push_data};
        r_wr_ptr        <= r_wr_ptr + (PTR_W+1)'(1);
      end
    end
  end

  // Unoccupied slots always have live=0, so only occupied live entries contribute.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_mem[PTR_W'(i)].live) begin
        w_mask[r_mem[PTR_W'(i)].rd] = 1'b1;
      end
    end
    w_mask[0] = 1'b0;
  end

  assign o_pending_mask = w_mask;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results
// drain from a FIFO, with a starvation-forced stall. Optional macro WB_ARB_BYPASS_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pipe_valid,
  input  logic [REG_W-1:0] i_pipe_rd,
  input  logic [XLEN-1:0]  i_pipe_data,
  output logic             o_pipe_stall,
  input  logic             i_lu_valid,
  output logic             o_lu_ready,
  input  logic [REG_W-1:0] i_lu_rd,
  input  logic [XLEN-1:0]  i_lu_data,
  output logic             o_rf_we,
  output logic [REG_W-1:0] o_rf_rd,
  output logic [XLEN-1:0]  o_rf_wdata,
  output logic [NREG-1:0]  o_pending_mask
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [CNT_W-1:0] r_starve_cnt;
  wb_entry_t        w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_pipe_req;
  logic             w_fifo_req;
  logic             w_head_dead;
  logic             w_lu_wr;
  logic             w_force;
  logic             w_push;
  logic             w_pop;
  logic             w_kill;
  wb_gnt_e          w_gnt;

  assign w_pipe_req  = i_pipe_valid && (i_pipe_rd != '0);
  assign w_fifo_req  = !w_empty && w_head.live;
  assign w_head_dead = !w_empty && !w_head.live;
  assign w_lu_wr     = i_lu_valid && !w_full && (i_lu_rd != '0);

  always_comb begin
    w_gnt   = GNT_NONE;
    w_force = 1'b0;
    if (w_fifo_req && (r_starve_cnt == CNT_W'(STARVE_MAX))) begin
      w_gnt   = GNT_FIFO;
      w_force = 1'b1;
    end else if (w_pipe_req) begin
      w_gnt = GNT_PIPE;
    end else if (w_fifo_req) begin
      w_gnt = GNT_FIFO;
    end else if (BYPASS_EN && w_empty && w_lu_wr) begin
      w_gnt = GNT_BYPASS;
    end
  end

  // Dead heads retire silently in any cycle; x0 LU results are accepted but never stored.
  assign w_push = w_lu_wr && (w_gnt != GNT_BYPASS);
  assign w_pop  = (w_gnt == GNT_FIFO) || w_head_dead;
  assign w_kill = (w_gnt == GNT_PIPE);

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_push         (w_push),
    .i_push_rd      (i_lu_rd),
    .i_push_data    (i_lu_data),
    .i_pop          (w_pop),
    .i_kill_en      (w_kill),
    .i_kill_rd      (i_pipe_rd),
    .o_head         (w_head),
    .o_empty        (w_empty),
    .o_full         (w_full),
    .o_pending_mask (o_pending_mask)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_empty || (w_gnt == GNT_FIFO)) begin
      r_starve_cnt <= '0;
    end else if ((w_gnt == GNT_PIPE) && w_fifo_req && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // Write-port mux; reset forces an idle port regardless of inputs.
  always_comb begin
    o_rf_we    = 1'b0;
    o_rf_rd    = '0;
    o_rf_wdata = '0;
    if (i_rst_n) begin
      case (w_gnt)
        GNT_PIPE: begin
          o_rf_we    = 1'b1;
          o_rf_rd    = i_pipe_rd;
          o_rf_wdata = i_pipe_data;
        end
        GNT_FIFO: begin
          o_rf_we    = 1'b1;
          o_rf_rd    = w_head.rd;
          o_rf_wdata = w_head.data;
        end
        GNT_BYPASS: begin
          o_rf_we    = 1'b1;
          o_rf_rd    = i_lu_rd;
          o_rf_wdata = i_lu_data;
        end
        default: begin
          o_rf_we = 1'b0;
        end
      endcase
    end
  end

  assign o_pipe_stall = i_rst_n && w_force && w_pipe_req;
  assign o_lu_ready   = !w_full;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int unsigned DEPTH      = 2;
  localparam int          STARVE_MAX = 3;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int SRC_NONE = 0;
  localparam int SRC_PIPE = 1;
  localparam int SRC_HEAD = 2;
  localparam int SRC_BYP  = 3;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_pipe_valid;
  logic [4:0]  i_pipe_rd;
  logic [31:0] i_pipe_data;
  logic        o_pipe_stall;
  logic        i_lu_valid;
  logic        o_lu_ready;
  logic [4:0]  i_lu_rd;
  logic [31:0] i_lu_data;
  logic        o_rf_we;
  logic [4:0]  o_rf_rd;
  logic [31:0] o_rf_wdata;
  logic [31:0] o_pending_mask;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_pipe_valid   (i_pipe_valid),
    .i_pipe_rd      (i_pipe_rd),
    .i_pipe_data    (i_pipe_data),
    .o_pipe_stall   (o_pipe_stall),
    .i_lu_valid     (i_lu_valid),
    .o_lu_ready     (o_lu_ready),
    .i_lu_rd        (i_lu_rd),
    .i_lu_data      (i_lu_data),
    .o_rf_we        (o_rf_we),
    .o_rf_rd        (o_rf_rd),
    .o_rf_wdata     (o_rf_wdata),
    .o_pending_mask (o_pending_mask)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } m_ent_t;

  m_ent_t      m_q[$];
  int          m_starve;
  int          m_starve_nxt;
  int          m_src;
  bit          m_kill, m_pop, m_push;
  logic [4:0]  m_kill_rd, m_push_rd;
  logic [31:0] m_push_data;

  logic        e_we, e_stall, e_ready;
  logic [4:0]  e_rd;
  logic [31:0] e_data, e_mask;

  logic        c_we, c_stall, c_ready, prev_stall;
  logic [4:0]  c_rd;
  logic [31:0] c_data, c_mask;

  int n_checks = 0;
  int n_errors = 0;
  int n_wait;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs and next state from the queue model and the current inputs.
  task automatic model_eval();
    bit empty, full, preq, freq, hdead, lwr;
    empty = (m_q.size() == 0);
    full  = (m_q.size() == int'(DEPTH));
    preq  = i_pipe_valid && (i_pipe_rd != 5'd0);
    freq  = 1'b0;
    hdead = 1'b0;
    if (!empty) begin
      freq  = m_q[0].live;
      hdead = !m_q[0].live;
    end
    lwr = i_lu_valid && !full && (i_lu_rd != 5'd0);

    m_src   = SRC_NONE;
    e_stall = 1'b0;
    if (freq && m_starve == STARVE_MAX) begin
      m_src   = SRC_HEAD;
      e_stall = preq;
    end else if (preq) m_src = SRC_PIPE;
    else if (freq) m_src = SRC_HEAD;
    else if (BYP && empty && lwr) m_src = SRC_BYP;

    e_we = 1'b1; e_rd = 5'd0; e_data = 32'd0;
    case (m_src)
      SRC_PIPE: begin e_rd = i_pipe_rd; e_data = i_pipe_data; end
      SRC_HEAD: begin e_rd = m_q[0].rd; e_data = m_q[0].data; end
      SRC_BYP:  begin e_rd = i_lu_rd;   e_data = i_lu_data;   end
      default:  e_we = 1'b0;
    endcase
    e_ready = !full;
    e_mask  = 32'd0;
    foreach (m_q[i]) if (m_q[i].live) e_mask[m_q[i].rd] = 1'b1;
    e_mask[0] = 1'b0;

    m_kill      = (m_src == SRC_PIPE);
    m_kill_rd   = i_pipe_rd;
    m_pop       = (m_src == SRC_HEAD) || hdead;
    m_push      = lwr && (m_src != SRC_BYP);
    m_push_rd   = i_lu_rd;
    m_push_data = i_lu_data;
    if (empty || m_src == SRC_HEAD) m_starve_nxt = 0;
    else if (m_src == SRC_PIPE && freq) m_starve_nxt = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else m_starve_nxt = m_starve;
  endtask

  task automatic model_commit();
    m_ent_t e;
    if (m_kill) begin
      foreach (m_q[i]) begin
        if (m_q[i].live && m_q[i].rd == m_kill_rd) begin
          e = m_q[i]; e.live = 1'b0; m_q[i] = e;
        end
      end
    end
    if (m_pop) void'(m_q.pop_front());
    if (m_push) begin
      e.rd = m_push_rd; e.data = m_push_data; e.live = 1'b1;
      m_q.push_back(e);
    end
    m_starve = m_starve_nxt;
  endtask

  // One clock cycle: drive at negedge, compare mid-cycle, advance model at posedge.
  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    i_pipe_valid = pv; i_pipe_rd = prd; i_pipe_data = pd;
    i_lu_valid = lv; i_lu_rd = lrd; i_lu_data = ld;
    #1;
    model_eval();
    c_we = o_rf_we; c_rd = o_rf_rd; c_data = o_rf_wdata;
    c_stall = o_pipe_stall; c_ready = o_lu_ready; c_mask = o_pending_mask;
    check_eq("rf_we", c_we, e_we);
    check_eq("rf_rd", c_rd, e_rd);
    check_eq("rf_wdata", c_data, e_data);
    check_eq("pipe_stall", c_stall, e_stall);
    check_eq("lu_ready", c_ready, e_ready);
    check_eq("pending_mask", c_mask, e_mask);
    check_eq("stall_twice", prev_stall & c_stall, 1'b0);
    prev_stall = c_stall;
    @(posedge i_clk);
    model_commit();
    @(negedge i_clk);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic mid_reset();
    i_pipe_valid = 1'b1; i_pipe_rd = 5'd3; i_lu_valid = 1'b1; i_lu_rd = 5'd4;
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("rst_rf_we", o_rf_we, 1'b0);
    check_eq("rst_rf_rd", o_rf_rd, 5'd0);
    check_eq("rst_rf_wdata", o_rf_wdata, 32'd0);
    check_eq("rst_stall", o_pipe_stall, 1'b0);
    check_eq("rst_ready", o_lu_ready, 1'b1);
    check_eq("rst_mask", o_pending_mask, 32'd0);
    m_q.delete();
    m_starve = 0;
    prev_stall = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_pipe_valid = 1'b0; i_lu_valid = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_pipe_valid = 1'b0; i_pipe_rd = 5'd0; i_pipe_data = 32'd0;
    i_lu_valid = 1'b0; i_lu_rd = 5'd0; i_lu_data = 32'd0;
    m_starve = 0;
    prev_stall = 1'b0;
    #1;
    check_eq("init_rf_we", o_rf_we, 1'b0);
    check_eq("init_ready", o_lu_ready, 1'b1);
    check_eq("init_mask", o_pending_mask, 32'd0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Idle port: LU result to x5
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    check_eq("idle_accept", c_ready, 1'b1);
    check_eq("idle_we_acc", c_we, BYP);
    idle();
    check_eq("idle_we_next", c_we, !BYP);
    check_eq("idle_mask5", c_mask[5], !BYP);
    idle();
    check_eq("idle_mask_clr", c_mask, 32'd0);

    // Starvation: x7 buffered while pipe writes x1..x4
    step(1'b1, 5'd20, 32'h20, 1'b1, 5'd7, 32'h77);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 5'(k), 32'(k), 1'b0, 5'd0, 32'd0);
      check_eq("starve_pipe_rd", c_rd, 5'(k));
    end
    step(1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 32'd0);
    check_eq("starve_stall", c_stall, 1'b1);
    check_eq("starve_drain_rd", c_rd, 5'd7);
    step(1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 32'd0);
    check_eq("starve_after_stall", c_stall, 1'b0);
    check_eq("starve_after_rd", c_rd, 5'd4);

    // Full: third LU result is held until the cycle after the first dequeue
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA);
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB);
    n_wait = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hC);
      if (c_ready) break;
      n_wait++;
    end
    check_eq("full_hold_cycles", n_wait, 3);
    repeat (6) idle();

    // WAW kill of buffered x9
    step(1'b1, 5'd20, 32'h20, 1'b1, 5'd9, 32'h11);
    step(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0);
    check_eq("waw_data", c_data, 32'h22);
    check_eq("waw_mask_before", c_mask[9], 1'b1);
    idle();
    check_eq("waw_dead_we", c_we, 1'b0);
    check_eq("waw_mask_after", c_mask[9], 1'b0);
    idle();

    // x0 writes from both sources
    step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    check_eq("x0_we", c_we, 1'b0);
    check_eq("x0_ready", c_ready, 1'b1);
    idle();
    check_eq("x0_mask", c_mask, 32'd0);

    // Reset with FIFO full and counter at 2
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA);
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB);
    step(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hC);
    check_eq("prerst_full", c_ready, 1'b0);
    check_eq("prerst_mask", c_mask, 32'h0000_0C00);
    mid_reset();
    repeat (3) begin
      idle();
      check_eq("postrst_we", c_we, 1'b0);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom);
    end
    repeat (8) idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback (the result selected by the writeback mux) and the long-latency unit (load-miss/divide) result channel. Pipeline writes have priority. Long-latency results are buffered in a small FIFO and drained into idle write-port cycles. A starvation counter forces a one-cycle pipeline stall so buffered results always retire. Sits between the writeback stage, the long-latency unit and the register file; exports a pending-destination mask to the hazard unit.

## Interface
- XLEN, 32, data width
- DEPTH, 2, long-latency result FIFO entries (power of two, ≥2)
- STARVE_MAX, 3, consecutive lost arbitration cycles before a forced drain (≥1)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_pipe_valid  in  1  writeback stage holds a register write this cycle
- i_pipe_rd  in  5  pipeline destination register
- i_pipe_data  in  XLEN  writeback mux output
- o_pipe_stall  out  1  pipeline must hold the writeback stage; pipe write not performed
- i_lu_valid  in  1  long-latency result offered
- o_lu_ready  out  1  result accepted when i_lu_valid && o_lu_ready
- i_lu_rd  in  5  long-latency destination register
- i_lu_data  in  XLEN  long-latency result
- o_rf_we  out  1  register-file write enable
- o_rf_rd  out  5  register-file write address
- o_rf_wdata  out  XLEN  register-file write data
- o_pending_mask  out  32  bit r set while a live FIFO entry targets xr; bit 0 always 0

## Operation
- x0 writes: pipe or LU with rd==0 are dropped. LU handshake completes normally; nothing is enqueued and the write port is not used.
- Pipe request: i_pipe_valid && i_pipe_rd!=0. FIFO request: head entry valid and live.
- Grant, in order:
  - Forced drain: FIFO request && starve_cnt==STARVE_MAX. Write the head, dequeue it, and assert o_pipe_stall if a pipe request exists.
  - Else pipe request: write pipe data. If the FIFO is non-empty and its head is live, starve_cnt increments (saturating).
  - Else FIFO request: write the head and dequeue it.
- starve_cnt clears when the head is written or the FIFO is empty.
- Killed entries: a granted pipe write whose rd matches a live FIFO entry marks that entry dead, because the pipe write is younger (WAW).
  - A dead head is dequeued without asserting o_rf_we, in any cycle, regardless of the grant.
  - A dead entry also clears its bit in o_pending_mask.
- o_lu_ready = !full. There is no same-cycle reuse of a slot freed by a dequeue.
- Enqueue stores {rd, data, live=1} at the tail. Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
- If enqueue of rd r and a pipe write to r happen in the same cycle, the enqueued entry stays live (the LU result is the younger one by hazard-unit contract).

## Timing
- Grant, o_rf_*, o_pipe_stall and o_lu_ready are combinational from registered FIFO/counter state and the current inputs. The FIFO, live bits and starve_cnt update on the rising edge.
- Latency:
  - Pipe write reaches the register file the same cycle it is presented.
  - An LU result reaches the register file no earlier than the cycle after acceptance (non-bypass).
  - An LU result waits at most STARVE_MAX+1 cycles once it reaches the head.
- o_pipe_stall never asserts for two consecutive cycles.
- Reset (asynchronous, mid-operation included) empties the FIFO, clears all live bits, and sets starve_cnt=0. Outputs during reset: o_rf_we=0, o_pipe_stall=0, o_lu_ready=1, o_pending_mask=0. o_rf_rd and o_rf_wdata are 0 when o_rf_we=0.

## Configuration
- WB_ARB_BYPASS_EN defined: when the FIFO is empty and there is no pipe request, an accepted LU result with rd!=0 is written to the register file in the acceptance cycle and not enqueued (zero extra latency).
- WB_ARB_BYPASS_EN undefined: every LU result with rd!=0 goes through the FIFO.

## Structure
- The shared package holds:
  - XLEN and the register-index width (5).
  - The FIFO entry struct {live, rd, data}.
  - The grant-source enum {GNT_NONE, GNT_PIPE, GNT_FIFO, GNT_BYPASS}.
- One sub-module: wb_result_fifo, which holds the entries, pointers, full/empty, per-entry live bits, a kill-by-rd input and the pending-mask output. The arbiter holds the grant logic and starve_cnt.

## Test plan
- Idle port: LU offers rd=5, data=0xDEAD_BEEF with no pipe request → accepted. Bypass off: o_rf_we with rd=5 the next cycle. Bypass on: o_rf_we the same cycle. o_pending_mask[5] is high only in the non-bypass case, for one cycle.
- Starvation: FIFO holds rd=7; pipe writes rd=1..4 on back-to-back cycles, STARVE_MAX=3 → three pipe writes, then in the 4th cycle o_pipe_stall=1 and rd=7 is written. The next cycle the rd=4 pipe write completes with no stall.
- Full: two LU results accepted with the pipe writing continuously → o_lu_ready=0. A third i_lu_valid is held until the cycle after the first dequeue.
- WAW kill: FIFO holds rd=9 data=0x11; pipe writes rd=9 data=0x22 → the register file gets 0x22. The entry later drains with o_rf_we=0, and o_pending_mask[9] drops the cycle after the pipe write.
- x0: pipe rd=0 and LU rd=0 in the same cycle → o_rf_we=0, LU handshake completes, FIFO stays empty.
- Reset mid-operation: assert i_rst_n=0 with the FIFO full and the counter at 2 → outputs take their reset values immediately. After release, no stale writes appear.
